// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: opcodes, FSM states and quad feature switch for the SPI RAM controller
// Macro SPI_RAM_CTRL_QUAD_EN enables quad opcodes (6Bh/32h) and the DUMMY state.
package spi_ram_pkg;
  localparam logic [7:0] CMD_READ = 8'h03, CMD_WRITE = 8'h02, CMD_QREAD = 8'h6B, CMD_QWRITE = 8'h32;
`ifdef SPI_RAM_CTRL_QUAD_EN
  localparam logic QUAD_EN = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_GAP} state_t;
`else
  localparam logic QUAD_EN = 1'b0;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_GAP} state_t;
`endif
  function automatic logic [7:0] opcode(input logic wr, input logic quad);
    return wr ? (quad ? CMD_QWRITE : CMD_WRITE) : (quad ? CMD_QREAD : CMD_READ);
  endfunction
endpackage

// File: rtl/spi_ram_shifter.sv
// spi_ram_shifter: 8-bit shift register, parallel load, 1- or 4-bit shift from sin
// Ports: load/load_val parallel load (wins over shift); shift/quad/sin shift step; q contents.
module spi_ram_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       shift,
  input  logic       quad,
  input  logic [3:0] sin,
  output logic [7:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (load) q <= load_val;
    else if (shift) q <= quad ? {q[3:0], sin} : {q[6:0], sin[0]};
endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: SPI/quad-SPI RAM master issuing command, 24-bit address, optional dummy and data phases
// Ports: req_* request handshake; wdata_* write byte stream; rdata/rdata_valid read stream;
// busy; spi_clk_out/spi_select/spi_d_out/spi_d_oe/spi_d_in pins. Quad support under SPI_RAM_CTRL_QUAD_EN.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int DUMMY_CYCLES = 2,
  parameter int LEN_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic                req_quad,
  input  logic [23:0]         req_addr,
  input  logic [LEN_BITS-1:0] req_len,
  input  logic [7:0]          wdata,
  input  logic                wdata_valid,
  output logic                wdata_ready,
  output logic [7:0]          rdata,
  output logic                rdata_valid,
  output logic                busy,
  output logic                spi_clk_out,
  output logic                spi_select,
  output logic [3:0]          spi_d_out,
  output logic [3:0]          spi_d_oe,
  input  logic [3:0]          spi_d_in
);
  // bit counter covers the longest phase: 24 address bits or the dummy count
  localparam int CNT_W = $clog2(DUMMY_CYCLES > 24 ? DUMMY_CYCLES : 24);
  state_t state, state_n;
  logic ph, ph_n, pend, pend_n, wr_r, quad_r, rdata_valid_n;
  logic sh_load, sh_shift, sh_quad, active, last_bit;
  logic [CNT_W-1:0] bit_cnt, bit_n;
  logic [LEN_BITS-1:0] byte_cnt, byte_n, len_r;
  logic [23:0] addr_r;
  logic [7:0] sh_val, sh_q, rd_byte, rdata_n;
  logic [3:0] sh_in;

  assign active = state != S_IDLE && state != S_GAP;
  assign last_bit = bit_cnt == (quad_r ? CNT_W'(1) : CNT_W'(7));
  assign sh_quad = quad_r && state == S_DATA;
  assign sh_in = (state == S_DATA && !wr_r) ? (quad_r ? spi_d_in : {3'b000, spi_d_in[1]}) : 4'h0;
  assign rd_byte = quad_r ? {sh_q[3:0], spi_d_in} : {sh_q[6:0], spi_d_in[1]};

  spi_ram_shifter u_shift (
    .clk(clk),
    .rst(rst),
    .load(sh_load),
    .load_val(sh_val),
    .shift(sh_shift),
    .quad(sh_quad),
    .sin(sh_in),
    .q(sh_q)
  );

  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      ph <= 1'b0;
      pend <= 1'b0;
      bit_cnt <= '0;
      byte_cnt <= '0;
      wr_r <= 1'b0;
      quad_r <= 1'b0;
      len_r <= '0;
      addr_r <= '0;
      rdata <= '0;
      rdata_valid <= 1'b0;
    end else begin
      state <= state_n;
      ph <= ph_n;
      pend <= pend_n;
      bit_cnt <= bit_n;
      byte_cnt <= byte_n;
      rdata <= rdata_n;
      rdata_valid <= rdata_valid_n;
      if (state == S_IDLE && req_valid) begin
        wr_r <= req_write;
        quad_r <= req_quad & QUAD_EN;
        len_r <= req_len;
        addr_r <= req_addr;
      end
    end

  // pend marks the clock-low slot where a write byte is awaited; ph=1 is the SPI high phase
  always_comb begin
    state_n = state;
    ph_n = ph;
    pend_n = pend;
    bit_n = bit_cnt;
    byte_n = byte_cnt;
    sh_load = 1'b0;
    sh_val = wdata;
    sh_shift = 1'b0;
    rdata_n = rdata;
    rdata_valid_n = 1'b0;
    if (state == S_IDLE) begin
      if (req_valid) begin
        state_n = S_CMD;
        bit_n = '0;
        byte_n = '0;
        sh_load = 1'b1;
        sh_val = opcode(req_write, req_quad & QUAD_EN);
      end
    end else if (state == S_GAP) begin
      bit_n = bit_cnt + CNT_W'(1);
      if (bit_cnt == CNT_W'(1)) begin
        state_n = S_IDLE;
        bit_n = '0;
      end
    end else if (pend) begin
      if (wdata_valid) begin
        pend_n = 1'b0;
        sh_load = 1'b1;
      end
    end else if (!ph) ph_n = 1'b1;
    else begin
      ph_n = 1'b0;
      sh_shift = 1'b1;
      bit_n = bit_cnt + CNT_W'(1);
      if (state == S_CMD && bit_cnt == CNT_W'(7)) begin
        state_n = S_ADDR;
        bit_n = '0;
        sh_load = 1'b1;
        sh_val = addr_r[23:16];
      end
      if (state == S_ADDR) begin
        sh_load = bit_cnt == CNT_W'(7) || bit_cnt == CNT_W'(15);
        sh_val = bit_cnt == CNT_W'(7) ? addr_r[15:8] : addr_r[7:0];
        if (bit_cnt == CNT_W'(23)) begin
          bit_n = '0;
          pend_n = wr_r;
          state_n = S_DATA;
`ifdef SPI_RAM_CTRL_QUAD_EN
          if (quad_r && !wr_r) state_n = S_DUMMY;
`endif
        end
      end
`ifdef SPI_RAM_CTRL_QUAD_EN
      if (state == S_DUMMY && bit_cnt == CNT_W'(DUMMY_CYCLES - 1)) begin
        state_n = S_DATA;
        bit_n = '0;
      end
`endif
      if (state == S_DATA && last_bit) begin
        bit_n = '0;
        rdata_n = wr_r ? rdata : rd_byte;
        rdata_valid_n = !wr_r;
        if (byte_cnt == len_r) state_n = S_GAP;
        else begin
          byte_n = byte_cnt + LEN_BITS'(1);
          pend_n = wr_r;
        end
      end
    end
  end

  always_comb begin
    req_ready = state == S_IDLE && !rst;
    busy = state != S_IDLE;
    wdata_ready = pend;
    spi_clk_out = ph;
    spi_select = !active;
    spi_d_oe = (state == S_CMD || state == S_ADDR) ? 4'b0001 :
               state == S_DATA ? (quad_r ? {4{wr_r}} : 4'b0001) : 4'b0000;
    spi_d_out = !active ? 4'h0 : sh_quad ? sh_q[7:4] : {3'b000, sh_q[7]};
  end
endmodule
